frame_tick_scheduler: RTL and testbench

//  Sequences the game datapath against the VGA frame. Derives a game_tick from VGA vsync, hands it
//  to the processor, and waits for tick_ack. Commits the processor's staged sprite positions
//  (player0, powerup0) to the VGA controller atomically, only at a frame start, so no frame tears.

---
 rtl/pacman_pkg.sv | 18 +
 rtl/frame_tick_scheduler_vsync_edge_sync.sv | 37 +++
 rtl/frame_tick_scheduler.sv | 120 ++++++++++++
 tb/tb_frame_tick_scheduler.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pacman_pkg.sv
// Shared widths, FSM encoding and helpers for the game/VGA frame scheduling logic.
package pacman_pkg;

  localparam int unsigned POS_W_DEF   = 32;
  localparam int unsigned FRAME_CNT_W = 16;
  localparam int unsigned OVR_CNT_W   = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StBusy  = 2'd1,
    StReady = 2'd2
  } tick_state_e;

  function automatic logic [OVR_CNT_W-1:0] sat_inc(input logic [OVR_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/frame_tick_scheduler_vsync_edge_sync.sv
// Synchronises the asynchronous, active-low VGA vsync and emits a one-cycle frame_start pulse
// three clocks after each falling edge.
module vsync_edge_sync (
  input  logic clock,
  input  logic resetn,
  input  logic vga_vs,
  output logic frame_start
);

  logic       sync1_q, sync2_q, sync3_q;
  logic [1:0] settle_q;
  logic       seen_high_q;
  logic       frame_start_q;

  // A fall only counts once vsync has genuinely been observed high after reset, so vsync held
  // low across reset release cannot fake a frame start.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync1_q       <= 1'b1;
      sync2_q       <= 1'b1;
      sync3_q       <= 1'b1;
      settle_q      <= 2'b00;
      seen_high_q   <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      sync1_q       <= vga_vs;
      sync2_q       <= sync1_q;
      sync3_q       <= sync2_q;
      settle_q      <= {settle_q[0], 1'b1};
      seen_high_q   <= seen_high_q | (settle_q[1] & sync2_q);
      frame_start_q <= seen_high_q & sync3_q & ~sync2_q;
    end
  end

  assign frame_start = frame_start_q;

endmodule

// File: rtl/frame_tick_scheduler.sv
// Paces the game datapath from VGA vsync and commits staged sprite positions only at frame start.
module frame_tick_scheduler
  import pacman_pkg::*;
#(
  parameter int unsigned      POS_W    = POS_W_DEF,
  parameter int unsigned      TICK_DIV = 2,
  parameter logic [POS_W-1:0] INIT_PX  = '0,
  parameter logic [POS_W-1:0] INIT_PY  = '0,
  parameter logic [POS_W-1:0] INIT_UX  = '0,
  parameter logic [POS_W-1:0] INIT_UY  = '0
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   vga_vs,
  input  logic [POS_W-1:0]       stage_p0_x,
  input  logic [POS_W-1:0]       stage_p0_y,
  input  logic [POS_W-1:0]       stage_u0_x,
  input  logic [POS_W-1:0]       stage_u0_y,
  input  logic                   tick_ack,
  input  logic                   overrun_clr,
  output logic                   game_tick,
  output logic [POS_W-1:0]       player0_x,
  output logic [POS_W-1:0]       player0_y,
  output logic [POS_W-1:0]       powerup0_x,
  output logic [POS_W-1:0]       powerup0_y,
  output logic [FRAME_CNT_W-1:0] frame_count,
  output logic                   overrun,
  output logic [OVR_CNT_W-1:0]   overrun_count
);

  localparam int unsigned DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  tick_state_e            state_q, state_d;
  logic [DIV_W-1:0]       div_q;
  logic                   frame_start, tick_due;
  logic                   ready_eff, issue_tick, commit, overrun_evt;
  logic                   game_tick_q, overrun_q;
  logic [POS_W-1:0]       p0x_q, p0y_q, u0x_q, u0y_q;
  logic [FRAME_CNT_W-1:0] frame_count_q;
  logic [OVR_CNT_W-1:0]   overrun_count_q;

  vsync_edge_sync u_vsync_edge_sync (
    .clock       (clock),
    .resetn      (resetn),
    .vga_vs      (vga_vs),
    .frame_start (frame_start)
  );

  assign tick_due = (div_q == DIV_W'(TICK_DIV - 1));

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_q <= StIdle;
    else         state_q <= state_d;
  end

  // An ack landing on the frame-start cycle is taken first, so BUSY behaves as READY then.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (frame_start && tick_due) state_d = StBusy;
      StBusy: begin
        if (frame_start && tick_ack) state_d = tick_due ? StBusy : StIdle;
        else if (tick_ack)           state_d = StReady;
      end
      StReady: if (frame_start) state_d = tick_due ? StBusy : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ready_eff   = (state_q == StReady) || ((state_q == StBusy) && tick_ack);
    issue_tick  = frame_start && tick_due && ((state_q == StIdle) || ready_eff);
    commit      = frame_start && ready_eff;
    overrun_evt = frame_start && tick_due && (state_q == StBusy) && !tick_ack;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      div_q           <= '0;
      frame_count_q   <= '0;
      game_tick_q     <= 1'b0;
      overrun_q       <= 1'b0;
      overrun_count_q <= '0;
      p0x_q           <= INIT_PX;
      p0y_q           <= INIT_PY;
      u0x_q           <= INIT_UX;
      u0y_q           <= INIT_UY;
    end else begin
      game_tick_q <= issue_tick;
      if (frame_start) begin
        frame_count_q <= frame_count_q + 1'b1;
        div_q         <= tick_due ? '0 : div_q + 1'b1;
      end
      if (commit) begin
        p0x_q <= stage_p0_x;
        p0y_q <= stage_p0_y;
        u0x_q <= stage_u0_x;
        u0y_q <= stage_u0_y;
      end
      // A fresh overrun beats a simultaneous clear.
      if (overrun_evt) begin
        overrun_q       <= 1'b1;
        overrun_count_q <= overrun_clr ? OVR_CNT_W'(1) : sat_inc(overrun_count_q);
      end else if (overrun_clr) begin
        overrun_q       <= 1'b0;
        overrun_count_q <= '0;
      end
    end
  end

  assign game_tick     = game_tick_q;
  assign player0_x     = p0x_q;
  assign player0_y     = p0y_q;
  assign powerup0_x    = u0x_q;
  assign powerup0_y    = u0y_q;
  assign frame_count   = frame_count_q;
  assign overrun       = overrun_q;
  assign overrun_count = overrun_count_q;

endmodule

// File: tb/tb_frame_tick_scheduler.sv
// Directed bench: one DUT with TICK_DIV=2 (a) and one with TICK_DIV=1 (b) sharing all inputs.
module tb_frame_tick_scheduler;

  logic        clock = 1'b0;
  logic        resetn;
  logic        vga_vs;
  logic [31:0] stage_p0_x, stage_p0_y, stage_u0_x, stage_u0_y;
  logic        tick_ack, overrun_clr;

  logic        tick_a, tick_b, ovr_a, ovr_b;
  logic [31:0] p0x_a, p0y_a, u0x_a, u0y_a, p0x_b, p0y_b, u0x_b, u0y_b;
  logic [15:0] fc_a, fc_b;
  logic [7:0]  oc_a, oc_b;

  int          n_checks = 0;
  int          n_fail = 0;
  int          tick_cnt_a = 0;
  int          tick_cnt_b = 0;
  int          base;
  logic        post_tick_a, post_tick_b;
  logic [31:0] pre_p0x_a, pre_p0x_b;

  always #5 clock = ~clock;

  frame_tick_scheduler #(
    .POS_W(32), .TICK_DIV(2),
    .INIT_PX(32'd5), .INIT_PY(32'd6), .INIT_UX(32'd7), .INIT_UY(32'd8)
  ) dut_a (
    .clock(clock), .resetn(resetn), .vga_vs(vga_vs),
    .stage_p0_x(stage_p0_x), .stage_p0_y(stage_p0_y),
    .stage_u0_x(stage_u0_x), .stage_u0_y(stage_u0_y),
    .tick_ack(tick_ack), .overrun_clr(overrun_clr), .game_tick(tick_a),
    .player0_x(p0x_a), .player0_y(p0y_a), .powerup0_x(u0x_a), .powerup0_y(u0y_a),
    .frame_count(fc_a), .overrun(ovr_a), .overrun_count(oc_a)
  );

  frame_tick_scheduler #(
    .POS_W(32), .TICK_DIV(1),
    .INIT_PX(32'd5), .INIT_PY(32'd6), .INIT_UX(32'd7), .INIT_UY(32'd8)
  ) dut_b (
    .clock(clock), .resetn(resetn), .vga_vs(vga_vs),
    .stage_p0_x(stage_p0_x), .stage_p0_y(stage_p0_y),
    .stage_u0_x(stage_u0_x), .stage_u0_y(stage_u0_y),
    .tick_ack(tick_ack), .overrun_clr(overrun_clr), .game_tick(tick_b),
    .player0_x(p0x_b), .player0_y(p0y_b), .powerup0_x(u0x_b), .powerup0_y(u0y_b),
    .frame_count(fc_b), .overrun(ovr_b), .overrun_count(oc_b)
  );

  always @(posedge clock) begin
    if (tick_a === 1'b1) tick_cnt_a <= tick_cnt_a + 1;
    if (tick_b === 1'b1) tick_cnt_b <= tick_cnt_b + 1;
  end

  task automatic do_reset(input logic vs_level);
    resetn = 1'b0;
    vga_vs = vs_level;
    repeat (2) @(posedge clock);
    #1 resetn = 1'b1;
    repeat (4) @(posedge clock);
  endtask

  // One vsync low pulse; ack/clr are driven in the cycle the internal frame_start is high.
  task automatic frame(input logic ack_on_fs, input logic clr_on_fs);
    @(posedge clock);
    #1 vga_vs = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    tick_ack    = ack_on_fs;
    overrun_clr = clr_on_fs;
    pre_p0x_a   = p0x_a;
    pre_p0x_b   = p0x_b;
    @(posedge clock);
    #1;
    tick_ack    = 1'b0;
    overrun_clr = 1'b0;
    post_tick_a = tick_a;
    post_tick_b = tick_b;
    repeat (3) @(posedge clock);
    #1 vga_vs = 1'b1;
    repeat (5) @(posedge clock);
  endtask

  task automatic pulse_ack();
    @(posedge clock);
    #1 tick_ack = 1'b1;
    @(posedge clock);
    #1 tick_ack = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++; if (p0x_a !== 32'd5) begin n_fail++; $display("FAIL rst_p0x got %0h exp 5", p0x_a); end
    n_checks++; if (p0y_a !== 32'd6) begin n_fail++; $display("FAIL rst_p0y got %0h exp 6", p0y_a); end
    n_checks++; if (u0x_a !== 32'd7) begin n_fail++; $display("FAIL rst_u0x got %0h exp 7", u0x_a); end
    n_checks++; if (u0y_a !== 32'd8) begin n_fail++; $display("FAIL rst_u0y got %0h exp 8", u0y_a); end
    n_checks++; if (fc_a !== 16'd0) begin n_fail++; $display("FAIL rst_fc got %0d exp 0", fc_a); end
    n_checks++; if (tick_a !== 1'b0) begin n_fail++; $display("FAIL rst_tick got %b exp 0", tick_a); end
    n_checks++; if (ovr_a !== 1'b0 || oc_a !== 8'd0) begin
      n_fail++; $display("FAIL rst_ovr got %b/%0d exp 0/0", ovr_a, oc_a);
    end
  endtask

  task automatic test_tick_div();
    do_reset(1'b1);
    base = tick_cnt_a;
    frame(1'b0, 1'b0);
    n_checks++; if (post_tick_a !== 1'b0) begin n_fail++; $display("FAIL div_f1_tick got %b exp 0", post_tick_a); end
    frame(1'b0, 1'b0);
    n_checks++; if (post_tick_a !== 1'b1) begin n_fail++; $display("FAIL div_f2_tick got %b exp 1", post_tick_a); end
    n_checks++; if (tick_a !== 1'b0) begin n_fail++; $display("FAIL tick_width got %b exp 0", tick_a); end
    frame(1'b0, 1'b0);
    frame(1'b0, 1'b0);
    n_checks++; if (tick_cnt_a - base !== 1) begin
      n_fail++; $display("FAIL div_tick_count got %0d exp 1", tick_cnt_a - base);
    end
    n_checks++; if (fc_a !== 16'd4) begin n_fail++; $display("FAIL div_frame_count got %0d exp 4", fc_a); end
    n_checks++; if (ovr_a !== 1'b1 || oc_a !== 8'd1) begin
      n_fail++; $display("FAIL div_overrun got %b/%0d exp 1/1", ovr_a, oc_a);
    end
    n_checks++; if (oc_b !== 8'd3) begin n_fail++; $display("FAIL div1_overrun_count got %0d exp 3", oc_b); end
  endtask

  task automatic test_ack_path();
    do_reset(1'b1);
    frame(1'b0, 1'b0);
    frame(1'b0, 1'b0);
    stage_p0_x = 32'h55;
    stage_u0_y = 32'h99;
    pulse_ack();
    repeat (3) @(posedge clock);
    #1;
    n_checks++; if (p0x_a !== 32'd5) begin n_fail++; $display("FAIL ack_hold got %0h exp 5", p0x_a); end
    frame(1'b0, 1'b0);
    n_checks++; if (pre_p0x_a !== 32'd5) begin n_fail++; $display("FAIL ack_pre got %0h exp 5", pre_p0x_a); end
    n_checks++; if (p0x_a !== 32'h55) begin n_fail++; $display("FAIL ack_commit_p0x got %0h exp 55", p0x_a); end
    n_checks++; if (u0y_a !== 32'h99 || p0y_a !== 32'd0 || u0x_a !== 32'd0) begin
      n_fail++; $display("FAIL ack_commit_all got %0h/%0h/%0h exp 0/0/99", p0y_a, u0x_a, u0y_a);
    end
    n_checks++; if (post_tick_a !== 1'b0) begin n_fail++; $display("FAIL ack_no_tick got %b exp 0", post_tick_a); end
    n_checks++; if (fc_a !== 16'd3) begin n_fail++; $display("FAIL ack_fc got %0d exp 3", fc_a); end
  endtask

  task automatic test_async_reset();
    @(posedge clock);
    #2 resetn = 1'b0;
    #1;
    n_checks++; if (p0x_a !== 32'd5 || u0y_a !== 32'd8) begin
      n_fail++; $display("FAIL async_pos got %0h/%0h exp 5/8", p0x_a, u0y_a);
    end
    n_checks++; if (fc_a !== 16'd0) begin n_fail++; $display("FAIL async_fc got %0d exp 0", fc_a); end
    n_checks++; if (ovr_b !== 1'b0 || oc_b !== 8'd0 || tick_a !== 1'b0) begin
      n_fail++; $display("FAIL async_flags got %b/%0d/%b exp 0/0/0", ovr_b, oc_b, tick_a);
    end
    @(posedge clock);
    #1 resetn = 1'b1;
    repeat (4) @(posedge clock);
  endtask

  task automatic test_no_ack();
    frame(1'b0, 1'b0);
    n_checks++; if (post_tick_b !== 1'b1) begin n_fail++; $display("FAIL noack_tick got %b exp 1", post_tick_b); end
    stage_p0_x = 32'h77;
    repeat (2) @(posedge clock);
    base = tick_cnt_b;
    frame(1'b0, 1'b0);
    n_checks++; if (post_tick_b !== 1'b0 || tick_cnt_b - base !== 0) begin
      n_fail++; $display("FAIL noack_second_tick got %b/%0d exp 0/0", post_tick_b, tick_cnt_b - base);
    end
    n_checks++; if (p0x_b !== 32'd5) begin n_fail++; $display("FAIL noack_hold got %0h exp 5", p0x_b); end
    n_checks++; if (ovr_b !== 1'b1 || oc_b !== 8'd1) begin
      n_fail++; $display("FAIL noack_overrun got %b/%0d exp 1/1", ovr_b, oc_b);
    end
  endtask

  task automatic test_coincident();
    stage_u0_x = 32'hAB;
    frame(1'b1, 1'b0);
    n_checks++; if (pre_p0x_b !== 32'd5) begin n_fail++; $display("FAIL coin_pre got %0h exp 5", pre_p0x_b); end
    n_checks++; if (p0x_b !== 32'h77 || u0x_b !== 32'hAB) begin
      n_fail++; $display("FAIL coin_commit got %0h/%0h exp 77/ab", p0x_b, u0x_b);
    end
    n_checks++; if (post_tick_b !== 1'b1) begin n_fail++; $display("FAIL coin_tick got %b exp 1", post_tick_b); end
    n_checks++; if (oc_b !== 8'd1) begin n_fail++; $display("FAIL coin_no_overrun got %0d exp 1", oc_b); end
  endtask

  task automatic test_overrun_sat();
    for (int i = 0; i < 300; i++) frame(1'b0, 1'b0);
    n_checks++; if (oc_b !== 8'hFF || ovr_b !== 1'b1) begin
      n_fail++; $display("FAIL sat_count got %b/%0h exp 1/ff", ovr_b, oc_b);
    end
    @(posedge clock);
    #1 overrun_clr = 1'b1;
    @(posedge clock);
    #1 overrun_clr = 1'b0;
    n_checks++; if (oc_b !== 8'd0 || ovr_b !== 1'b0) begin
      n_fail++; $display("FAIL clr got %b/%0h exp 0/0", ovr_b, oc_b);
    end
    frame(1'b0, 1'b1);
    n_checks++; if (oc_b !== 8'd1 || ovr_b !== 1'b1) begin
      n_fail++; $display("FAIL clr_vs_new got %b/%0h exp 1/1", ovr_b, oc_b);
    end
  endtask

  task automatic test_vs_low_reset();
    do_reset(1'b0);
    repeat (6) @(posedge clock);
    #1;
    n_checks++; if (fc_a !== 16'd0 || fc_b !== 16'd0) begin
      n_fail++; $display("FAIL vslow_fc got %0d/%0d exp 0/0", fc_a, fc_b);
    end
    vga_vs = 1'b1;
    repeat (6) @(posedge clock);
    #1;
    n_checks++; if (fc_b !== 16'd0) begin n_fail++; $display("FAIL vslow_rise got %0d exp 0", fc_b); end
    frame(1'b0, 1'b0);
    n_checks++; if (fc_b !== 16'd1) begin n_fail++; $display("FAIL vslow_then_fall got %0d exp 1", fc_b); end
  endtask

  initial begin
    resetn      = 1'b0;
    vga_vs      = 1'b1;
    stage_p0_x  = '0;
    stage_p0_y  = '0;
    stage_u0_x  = '0;
    stage_u0_y  = '0;
    tick_ack    = 1'b0;
    overrun_clr = 1'b0;
    post_tick_a = 1'b0;
    post_tick_b = 1'b0;
    pre_p0x_a   = '0;
    pre_p0x_b   = '0;
    base        = 0;
    #23 resetn = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    test_reset();
    test_tick_div();
    test_ack_path();
    test_async_reset();
    test_no_ack();
    test_coincident();
    test_overrun_sat();
    test_vs_low_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
